// File: rtl/fifo_pkg.sv
// Shared FIFO package: default geometry, address/occupancy width helpers.
package fifo_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_DEPTH  = 16;

  // Ceiling log2, usable in constant expressions (parameter defaults, widths).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Occupancy counter must hold 0..DEPTH inclusive, so it needs one bit more
  // than the pointers.
  function automatic int count_w(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous
// read port. Contents are not reset; the controller tracks validity.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port: store wdata at waddr on the rising edge when enabled.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port is combinational so the head entry is visible the cycle after
  // it is written.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ring_fifo_ctl.sv
// Ring-buffer FIFO controller: head/tail pointers, occupancy count, threshold
// flags and sticky overflow/underflow, around a fifo_mem storage array.
module ring_fifo_ctl
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AFULL_TH  = 14,
  parameter int AEMPTY_TH = 2,
  localparam int ADDR_W   = clog2(DEPTH),
  localparam int CNT_W    = count_w(DEPTH)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [DATA_W-1:0] dataIn,
  input  logic              push,
  input  logic              pop,
  input  logic              clrErr,
  output logic [DATA_W-1:0] dataOut,
  output logic              full,
  output logic              empty,
  output logic              almostFull,
  output logic              almostEmpty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_DEPTH  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_AFULL  = CNT_W'(AFULL_TH);
  localparam logic [CNT_W-1:0]  CNT_AEMPTY = CNT_W'(AEMPTY_TH);

  logic [ADDR_W-1:0] head_q, head_d;
  logic [ADDR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              push_ok, pop_ok;
  logic              mem_we;

  // Status flags come straight from the count register, never from requests.
  assign full        = (count_q == CNT_DEPTH);
  assign empty       = (count_q == '0);
  assign almostFull  = (count_q >= CNT_AFULL);
  assign almostEmpty = (count_q <= CNT_AEMPTY);
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // accepted whenever a pop is accepted alongside it.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Storage writes are suppressed during reset so reset truly discards the push.
  assign mem_we = push_ok & resetn;

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (push_ok) begin
      head_d = head_q + PTR_ONE;
    end
    if (pop_ok) begin
      tail_d = tail_q + PTR_ONE;
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // Clear first so that an error in the same cycle leaves the flag set.
    if (clrErr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (push & ~push_ok) begin
      overflow_d = 1'b1;
    end
    if (pop & empty) begin
      underflow_d = 1'b1;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clock (clock),
    .we    (mem_we),
    .waddr (head_q),
    .wdata (dataIn),
    .raddr (tail_q),
    .rdata (dataOut)
  );

endmodule

// File: tb/tb_ring_fifo_ctl.sv
// Self-checking bench for ring_fifo_ctl: directed scenarios followed by
// randomized push/pop traffic, compared against a queue-based reference.
module tb_ring_fifo_ctl;

  localparam int DATA_W    = 4;
  localparam int DEPTH     = 16;
  localparam int AFULL_TH  = 14;
  localparam int AEMPTY_TH = 2;

  logic              clock;
  logic              resetn;
  logic [DATA_W-1:0] dataIn;
  logic              push;
  logic              pop;
  logic              clrErr;
  logic [DATA_W-1:0] dataOut;
  logic              full;
  logic              empty;
  logic              almostFull;
  logic              almostEmpty;
  logic [4:0]        count;
  logic              overflow;
  logic              underflow;

  int n_vec;
  int n_err;

  // Reference state: contents as an ordered queue plus the two sticky flags.
  logic [DATA_W-1:0] model_q[$];
  bit                m_ovf;
  bit                m_udf;

  ring_fifo_ctl #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .AFULL_TH  (AFULL_TH),
    .AEMPTY_TH (AEMPTY_TH)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .dataIn      (dataIn),
    .push        (push),
    .pop         (pop),
    .clrErr      (clrErr),
    .dataOut     (dataOut),
    .full        (full),
    .empty       (empty),
    .almostFull  (almostFull),
    .almostEmpty (almostEmpty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard time limit so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus (driven at negedge), advance the reference at
  // the rising edge, then compare every output shortly after the edge.
  task automatic step(input logic rn, input logic ps, input logic pp,
                      input logic cl, input logic [DATA_W-1:0] d);
    bit was_empty;
    bit pop_ok;
    bit push_ok;
    int n;
    resetn = rn;
    push   = ps;
    pop    = pp;
    clrErr = cl;
    dataIn = d;
    @(posedge clock);
    if (!rn) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      was_empty = (model_q.size() == 0);
      pop_ok    = pp && !was_empty;
      push_ok   = ps && ((model_q.size() < DEPTH) || pop_ok);
      if (pop_ok)  void'(model_q.pop_front());
      if (push_ok) model_q.push_back(d);
      if (cl) begin
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end
      if (ps && !push_ok) m_ovf = 1'b1;
      if (pp && was_empty) m_udf = 1'b1;
    end
    #1;
    n = model_q.size();
    check("count",       32'(count),       32'(n));
    check("empty",       32'(empty),       32'(n == 0));
    check("full",        32'(full),        32'(n == DEPTH));
    check("almostFull",  32'(almostFull),  32'(n >= AFULL_TH));
    check("almostEmpty", 32'(almostEmpty), 32'(n <= AEMPTY_TH));
    check("overflow",    32'(overflow),    32'(m_ovf));
    check("underflow",   32'(underflow),   32'(m_udf));
    if (n > 0) begin
      check("dataOut", 32'(dataOut), 32'(model_q[0]));
    end
    $display("t=%0t rn=%b push=%b pop=%b clr=%b din=%h -> count=%0d dout=%h ovf=%b udf=%b",
             $time, rn, ps, pp, cl, d, count, dataOut, overflow, underflow);
    @(negedge clock);
  endtask

  initial begin
    logic [DATA_W-1:0] v;
    n_vec  = 0;
    n_err  = 0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    resetn = 1'b0;
    push   = 1'b0;
    pop    = 1'b0;
    clrErr = 1'b0;
    dataIn = '0;
    @(negedge clock);

    // Reset then idle.
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);

    // Fill with 1..F then 0, then drain in order.
    for (int i = 1; i <= 16; i++) begin
      v = DATA_W'(i);
      step(1'b1, 1'b1, 1'b0, 1'b0, v);
    end
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);

    // Refill, overflow with 0xA, then clear the flag.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, 1'b0, DATA_W'($urandom));
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'hA);
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'h0);

    // Full FIFO with simultaneous push 0x5 and pop, across pointer wrap.
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 4'h5);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);

    // Empty FIFO: pop and push 0x7 together, then one idle cycle.
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'h7);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    // Single entry with push & pop: new word becomes head.
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'h9);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);

    // Eight entries queued, reset mid-stream with push held, then push 0x3.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0, DATA_W'($urandom));
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'hE);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h3);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);

    // Randomized traffic, alternating fill-biased and drain-biased phases.
    for (int i = 0; i < 1500; i++) begin
      int  ph;
      logic ps, pp, cl, rn;
      ph = (i / 125) % 2;
      ps = ($urandom_range(99) < (ph != 0 ? 80 : 30));
      pp = ($urandom_range(99) < (ph != 0 ? 30 : 80));
      cl = ($urandom_range(99) < 5);
      rn = ($urandom_range(199) != 0);
      step(rn, ps, pp, cl, DATA_W'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ring_fifo_ctl.md
# ring_fifo_ctl

Parametrised ring-buffer FIFO, the next generation of the team's push/pop FIFOs. Generalises data width and depth, accepts push and pop in the same cycle, and adds occupancy count, almost-full/almost-empty thresholds and sticky error flags. Drop-in buffer between a producer and consumer in one clock domain. Also serves as the DUT side of FIFO-equivalence models.

## Interface
- DATA_W, 4: data width in bits.
- DEPTH, 16: number of entries; power of two, ≥ 2.
- AFULL_TH, 14: almostFull asserted when count ≥ AFULL_TH.
- AEMPTY_TH, 2: almostEmpty asserted when count ≤ AEMPTY_TH.
- ADDR_W (localparam): clog2(DEPTH).
- clock  in  1  single clock; all state updates on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- dataIn  in  DATA_W  write data, sampled when a push is accepted.
- push  in  1  push request.
- pop  in  1  pop request.
- clrErr  in  1  clears overflow/underflow (synchronous).
- dataOut  out  DATA_W  head of queue; defined only while ~empty.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almostFull  out  1  count ≥ AFULL_TH.
- almostEmpty  out  1  count ≤ AEMPTY_TH.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: push refused.
- underflow  out  1  sticky: pop on empty.

## Operation
- State: head, tail (ADDR_W bits, natural wrap DEPTH-1 → 0), count register, error flags, DEPTH×DATA_W storage.
- popOk = pop & ~empty; pushOk = push & (~full | popOk).
- pushOk: mem[head] ← dataIn; head ← head+1.
- popOk: tail ← tail+1.
- count ← count + pushOk − popOk. Both accepted: count unchanged, including when full.
- Push on full without pop: NOOP on data and pointers; overflow ← 1.
- Pop on empty: NOOP; underflow ← 1. A simultaneous push still proceeds.
- clrErr clears both flags. A new error in the same cycle wins (flag = 1).
- dataOut = mem[tail], read combinationally. Storage is not reset, so dataOut is don't-care while empty.
- All status flags derive combinationally from the count register only, so they are glitch-free relative to the clock.
- Reset (resetn = 0 at an edge): head = tail = 0, count = 0, overflow = underflow = 0. Reset overrides push and pop in that cycle, and any in-flight contents are discarded.
- Outputs after reset: empty = 1, full = 0, almostEmpty = 1, almostFull = 0, count = 0, flags = 0.

## Timing
- Write-to-read latency is 1 cycle: data pushed into an empty FIFO at edge N appears on dataOut, with empty = 0, after edge N.
- Pop takes effect at the edge; the next entry is on dataOut after that edge.
- Status outputs and count reflect requests accepted at the most recent edge. There is no lookahead.
- Full FIFO with push & pop: oldest entry leaves and dataIn is written in the same cycle; full stays 1.
- Single-entry FIFO with push & pop: the pushed word becomes the head next cycle; empty stays 0.
- Throughput is one push and one pop per cycle, sustained.

## Structure
- Shared package fifo_pkg holds:
  - clog2 function;
  - default DATA_W/DEPTH constants;
  - the occupancy-width rule (ADDR_W+1).
- The package is reused by the comparison models and other FIFO variants.
- Sub-module fifo_mem: DEPTH×DATA_W register array with one write port (we, waddr, wdata) and one asynchronous read port (raddr → rdata).
- Pointer, count and flag logic stays in ring_fifo_ctl.

## Test plan
- Reset, then idle -> empty = 1, almostEmpty = 1, count = 0, overflow = underflow = 0.
- Push 0x1..0xF then 0x0 (16 pushes, default params) -> count = 16, full = 1, almostFull from count 14. Then 16 pops -> dataOut sequence 0x1..0xF, 0x0; empty = 1.
- Full FIFO, push 0xA with no pop -> count stays 16, contents unchanged, overflow = 1. Then clrErr -> overflow = 0.
- Full FIFO, push 0x5 & pop together for 20 cycles -> count = 16 throughout. Output order is preserved across head/tail wrap; 0x5 words emerge after the 16 original entries.
- Empty FIFO, pop & push 0x7 together -> underflow = 1, count = 1, dataOut = 0x7 next cycle.
- Eight entries queued, resetn low for one edge mid-stream with push = 1 -> count = 0, empty = 1, pointers at 0. A push of 0x3 after release reads back 0x3.
